// File: rtl/relu.sv
// Vector ReLU stage: clamps negative two's-complement elements to zero,
// LANES elements per clock, result vector held in registers.
//
// Ports:
//   clk           - rising-edge clock
//   reset         - asynchronous active-high reset, clears all state
//   enable        - level start/hold request
//   input_vector  - WIDTH x DATA_WIDTH source operands (read live in RUN)
//   output_vector - WIDTH x DATA_WIDTH registered results
//   done          - registered completion flag
module relu #(
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] input_vector  [WIDTH],
    output logic [DATA_WIDTH-1:0] output_vector [WIDTH],
    output logic                  done
);

    localparam int K     = WIDTH / LANES;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("relu: WIDTH must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   out_q  [WIDTH];
    logic [DATA_WIDTH-1:0]   relu_d [WIDTH];

    // Sign bit set means negative: clamp to zero, else pass through.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            relu_d[i] = input_vector[i][DATA_WIDTH-1]
                      ? '0 : input_vector[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (enable) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        // Element i belongs to chunk i/LANES; only the
                        // current chunk's registers load this edge.
                        for (int i = 0; i < WIDTH; i++) begin
                            if (IDX_W'(i / LANES) == idx_q) begin
                                out_q[i] <= relu_d[i];
                            end
                        end
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        // Abort: partial writes are kept, no done pulse.
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign output_vector = out_q;
    assign done          = done_q;

endmodule

// File: tb/tb_relu.sv
// Self-checking bench for relu: directed vectors, latency, abort,
// async reset mid-run.
module tb_relu;

    localparam int W  = 128;
    localparam int DW = 16;
    localparam int NT = 8;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [DW-1:0] in_v  [W];
    logic [DW-1:0] out_v [W];
    logic          done;

    logic [DW-1:0] exp_v [W];

    int n_checks;
    int n_fail;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
    } vec_t;

    vec_t tbl [NT];

    relu #(
        .WIDTH     (W),
        .DATA_WIDTH(DW),
        .LANES     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .input_vector (in_v),
        .output_vector(out_v),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_vec(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < W; i++) begin
            if (out_v[i] !== exp_v[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d elements wrong, first [%0d] got %0h expected %0h",
                     name, bad, first, out_v[first], exp_v[first]);
        end
    endtask

    // Called at a negedge with enable low; returns edges from the
    // enable-sampling edge until done is seen high (bounded).
    task automatic start_and_wait(output int n);
        n = 0;
        enable = 1'b1;
        @(posedge clk);
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic finish_run(input string name);
        int hi;
        hi = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) hi++;
        end
        check({name, " done held"}, hi, 3);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check({name, " done falls"}, int'(done), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int hi;
        n_checks = 0;
        n_fail   = 0;
        enable   = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < W; i++) in_v[i] = '0;

        tbl[0] = '{16'h8000, 16'h0000};
        tbl[1] = '{16'hFFFF, 16'h0000};
        tbl[2] = '{16'h0001, 16'h0001};
        tbl[3] = '{16'h7FFF, 16'h7FFF};
        tbl[4] = '{16'h0000, 16'h0000};
        tbl[5] = '{16'hFE00, 16'h0000};
        tbl[6] = '{16'h0200, 16'h0200};
        tbl[7] = '{16'h1000, 16'h1000};

        // 1. Reset state
        #12;
        for (int i = 0; i < W; i++) exp_v[i] = '0;
        check("reset done", int'(done), 0);
        check_vec("reset outputs");
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) hi++;
        end
        check("idle done low", hi, 0);
        check_vec("idle outputs");
        @(negedge clk);

        // 2/3. Mixed vector with latency
        for (int i = 0; i < W; i++) begin
            in_v[i]  = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
            exp_v[i] = (i % 2 == 0) ? 16'h0200 : 16'h0000;
        end
        in_v[0] = 16'h0000; exp_v[0] = 16'h0000;
        in_v[1] = 16'hF000; exp_v[1] = 16'h0000;
        in_v[2] = 16'h1000; exp_v[2] = 16'h1000;
        start_and_wait(n);
        check("mixed latency", n, 16);
        check_vec("mixed result");
        finish_run("mixed");

        // 4. Table-driven boundary vectors
        for (int i = 0; i < W; i++) in_v[i] = tbl[i % NT].din;
        start_and_wait(n);
        check("table latency", n, 16);
        for (int i = 0; i < W; i++) begin
            check($sformatf("table[%0d]", i), int'(out_v[i]),
                  int'(tbl[i % NT].dexp));
            exp_v[i] = tbl[i % NT].dexp;
        end
        finish_run("table");

        // 5. Abort after 5 RUN edges
        for (int i = 0; i < W; i++) in_v[i] = 16'h0100;
        enable = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        hi = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) hi++;
        end
        check("abort no done", hi, 0);
        for (int i = 0; i < 40; i++) exp_v[i] = 16'h0100;
        check_vec("abort partial");
        @(negedge clk);
        for (int i = 0; i < W; i++) exp_v[i] = 16'h0100;
        start_and_wait(n);
        check("rerun latency", n, 16);
        check_vec("rerun result");
        finish_run("rerun");

        // 6. Async reset at RUN edge 8
        for (int i = 0; i < W; i++) in_v[i] = 16'h0300;
        enable = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < W; i++) exp_v[i] = '0;
        check("midrun reset done", int'(done), 0);
        check_vec("midrun reset outputs");
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            in_v[i]  = (i % 3 == 0) ? 16'hC000 : 16'h0300;
            exp_v[i] = (i % 3 == 0) ? 16'h0000 : 16'h0300;
        end
        start_and_wait(n);
        check("post-reset latency", n, 16);
        check_vec("post-reset result");
        finish_run("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
